// File: rtl/core_ctrl.sv
// core_ctrl: cycle-by-cycle instruction sequencer for the 8x8 systolic core (one kij pass per start).
// Define CORE_CTRL_ACC_EN to build the psum accumulation walker (ACC state and acc_start port).
module core_ctrl #(
    parameter int          col     = 8,
    parameter int          len_nij = 36,
`ifdef CORE_CTRL_ACC_EN
    parameter int          in_w    = 6,
    parameter int          out_w   = 4,
`endif
    parameter int          ksize   = 3,
    parameter int          gap     = 10,
    parameter logic [10:0] wbase   = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
`ifdef CORE_CTRL_ACC_EN
    input  logic        acc_start,
`endif
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  phase,
    output logic        sfp_clear,
    output logic        out_valid
);
    localparam int          len_kij   = ksize * ksize;
    localparam logic [7:0]  col_c     = 8'(col);
    localparam logic [7:0]  nij_c     = 8'(len_nij);
    localparam logic [7:0]  gap_c     = 8'(gap);
    localparam logic [4:0]  kij_lim   = 5'(len_kij);
    localparam logic [10:0] nij_a     = 11'(len_nij);
    localparam logic [33:0] inst_idle = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        st_idle = 4'd0, st_wl0 = 4'd1, st_wld = 4'd2, st_gap  = 4'd3, st_al0 = 4'd4,
        st_exe  = 4'd5, st_ofr = 4'd6, st_done = 4'd7, st_acc = 4'd8
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  pops, pops_n;
    logic [7:0]  wrs, wrs_n;
    logic        wr_pend, wr_pend_n;
    logic [10:0] psum_base, psum_base_n;
    logic [33:0] inst_d;
    logic        done_d, clear_d, valid_d;

`ifdef CORE_CTRL_ACC_EN
    localparam logic [4:0]  sub_last  = 5'(len_kij + 2);
    localparam logic [4:0]  kij_c5    = 5'(len_kij);
    localparam logic [3:0]  kj_last   = 4'(ksize - 1);
    localparam logic [3:0]  ocol_last = 4'(out_w - 1);
    localparam logic [7:0]  o_last    = 8'(out_w * out_w - 1);
    localparam logic [10:0] in_w_a    = 11'(in_w);
    localparam logic [10:0] row_step  = 11'(in_w - out_w + 1);

    logic [7:0]  o_cnt, o_cnt_n;
    logic [4:0]  sub, sub_n;
    logic [3:0]  kj, kj_n;
    logic [3:0]  ocol, ocol_n;
    logic [10:0] k_ofs, k_ofs_n;
    logic [10:0] ki_ofs, ki_ofs_n;
    logic [10:0] o_base, o_base_n;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= st_idle;
            cnt       <= '0;
            pops      <= '0;
            wrs       <= '0;
            wr_pend   <= 1'b0;
            psum_base <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pops      <= pops_n;
            wrs       <= wrs_n;
            wr_pend   <= wr_pend_n;
            psum_base <= psum_base_n;
        end
    end

`ifdef CORE_CTRL_ACC_EN
    // Address walker: k*len_nij, ki*in_w and orow*in_w+ocol are kept as running sums.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_cnt  <= '0;
            sub    <= '0;
            kj     <= '0;
            ocol   <= '0;
            k_ofs  <= '0;
            ki_ofs <= '0;
            o_base <= '0;
        end else begin
            o_cnt  <= o_cnt_n;
            sub    <= sub_n;
            kj     <= kj_n;
            ocol   <= ocol_n;
            k_ofs  <= k_ofs_n;
            ki_ofs <= ki_ofs_n;
            o_base <= o_base_n;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 8'd1;
        pops_n      = pops;
        wrs_n       = wrs;
        wr_pend_n   = 1'b0;
        psum_base_n = psum_base;
        inst_d      = inst_idle;
        done_d      = 1'b0;
        clear_d     = 1'b0;
        valid_d     = 1'b0;
`ifdef CORE_CTRL_ACC_EN
        o_cnt_n  = o_cnt;
        sub_n    = sub;
        kj_n     = kj;
        ocol_n   = ocol;
        k_ofs_n  = k_ofs;
        ki_ofs_n = ki_ofs;
        o_base_n = o_base;
`endif
        case (state)
            st_idle: begin
                cnt_n  = '0;
                pops_n = '0;
                wrs_n  = '0;
`ifdef CORE_CTRL_ACC_EN
                o_cnt_n  = '0;
                sub_n    = '0;
                kj_n     = '0;
                ocol_n   = '0;
                k_ofs_n  = '0;
                ki_ofs_n = '0;
                o_base_n = '0;
`endif
                if (start && ({1'b0, kij} < kij_lim)) begin
                    state_n     = st_wl0;
                    psum_base_n = 11'(kij) * nij_a;
                end
`ifdef CORE_CTRL_ACC_EN
                else if (acc_start) begin
                    state_n = st_acc;
                end
`endif
            end
            // L0 is written one cycle behind each xmem read because of the SRAM latency.
            st_wl0: begin
                if (cnt < col_c) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = wbase + 11'(cnt);
                end
                if (cnt != 8'd0) inst_d[2] = 1'b1;
                if (cnt == col_c) begin
                    state_n = st_wld;
                    cnt_n   = '0;
                end
            end
            st_wld: begin
                if (cnt < col_c) inst_d[3] = 1'b1;
                if (cnt != 8'd0) inst_d[0] = 1'b1;
                if (cnt == col_c) begin
                    state_n = st_gap;
                    cnt_n   = '0;
                end
            end
            st_gap: begin
                if (cnt == gap_c - 8'd1) begin
                    state_n = st_al0;
                    cnt_n   = '0;
                end
            end
            st_al0: begin
                if (cnt < nij_c) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(cnt);
                end
                if (cnt != 8'd0) inst_d[2] = 1'b1;
                if (cnt == nij_c) begin
                    state_n = st_exe;
                    cnt_n   = '0;
                end
            end
            st_exe: begin
                if (cnt < nij_c) inst_d[3] = 1'b1;
                if (cnt != 8'd0) inst_d[1] = 1'b1;
                if (cnt == nij_c) begin
                    state_n = st_ofr;
                    cnt_n   = '0;
                end
            end
            // Every pop schedules exactly one psum write on the following cycle.
            st_ofr: begin
                if (ofifo_valid && (pops < nij_c)) begin
                    inst_d[6] = 1'b1;
                    pops_n    = pops + 8'd1;
                    wr_pend_n = 1'b1;
                end
                if (wr_pend) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = psum_base + 11'(wrs);
                    wrs_n         = wrs + 8'd1;
                    if (wrs == nij_c - 8'd1) state_n = st_done;
                end
            end
            st_done: begin
                done_d  = 1'b1;
                state_n = st_idle;
            end
`ifdef CORE_CTRL_ACC_EN
            st_acc: begin
                sub_n = sub + 5'd1;
                if (sub == 5'd0) clear_d = 1'b1;
                if ((sub >= 5'd1) && (sub <= kij_c5)) begin
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = k_ofs + ki_ofs + o_base + 11'(kj);
                    k_ofs_n       = k_ofs + nij_a;
                    if (kj == kj_last) begin
                        kj_n     = '0;
                        ki_ofs_n = ki_ofs + in_w_a;
                    end else begin
                        kj_n = kj + 4'd1;
                    end
                end
                if ((sub >= 5'd2) && (sub <= kij_c5 + 5'd1)) inst_d[33] = 1'b1;
                if (sub == sub_last) begin
                    valid_d  = 1'b1;
                    sub_n    = '0;
                    kj_n     = '0;
                    k_ofs_n  = '0;
                    ki_ofs_n = '0;
                    o_cnt_n  = o_cnt + 8'd1;
                    if (ocol == ocol_last) begin
                        ocol_n   = '0;
                        o_base_n = o_base + row_step;
                    end else begin
                        ocol_n   = ocol + 4'd1;
                        o_base_n = o_base + 11'd1;
                    end
                    if (o_cnt == o_last) state_n = st_done;
                end
            end
`endif
            default: state_n = st_idle;
        endcase
    end

    // All outputs are registered copies of the decode of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst      <= inst_idle;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase     <= 4'd0;
            sfp_clear <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            inst      <= inst_d;
            busy      <= (state != st_idle);
            done      <= done_d;
            phase     <= state;
            sfp_clear <= clear_d;
            out_valid <= valid_d;
        end
    end
endmodule
